// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller.
//   RF_NUM_REQ / RF_DATA_W / RF_ADDR_W : default block parameters
//   req_id_t                           : requester index type
//   REQ_ALU / REQ_LSU / REQ_MUL        : requester slot numbers
//   wb_req_t                           : one write-back request {addr, data}
package rf_ctrl_pkg;

  localparam int RF_NUM_REQ = 3;
  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;

  // Index width that stays legal for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RF_ID_W = id_w(RF_NUM_REQ);

  typedef logic [RF_ID_W-1:0] req_id_t;

  localparam req_id_t REQ_ALU = req_id_t'(0);
  localparam req_id_t REQ_LSU = req_id_t'(1);
  localparam req_id_t REQ_MUL = req_id_t'(2);

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_valid : request vector, one bit per requester
//   i_ptr   : highest-priority requester for this cycle
//   o_grant : one-hot grant (all-zero when nothing is valid)
//   o_id    : index of the granted requester (0 when nothing is valid)
//   o_any   : at least one request was granted
// The priority pointer is held by the instantiating block.
module rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic               o_any
);

  int             w_sum;
  logic [ID_W-1:0] w_idx;

  // Walk the requesters starting at i_ptr, wrapping once; the first valid
  // one wins.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = ID_W'(w_sum);
      if (!o_any && i_valid[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back controller for the register file's single write port.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_req_valid/addr/data : write-back requests (slice k = requester k)
//   o_req_ready           : one-hot accept, round-robin among requesters
//   i_issue_valid/rd      : issuing instruction marks its destination busy
//   i_flush               : clears the busy scoreboard
//   i_rs1_addr/i_rs2_addr : hazard query addresses
//   o_rs1/rs2/rd_busy     : scoreboard bits for the query and issue addresses
//   o_rd_wren/addr/data   : registered register-file write port
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_issue_valid,
  input  logic [ADDR_W-1:0]         i_issue_rd,
  input  logic                      i_flush,
  input  logic [ADDR_W-1:0]         i_rs1_addr,
  input  logic [ADDR_W-1:0]         i_rs2_addr,
  output logic                      o_rs1_busy,
  output logic                      o_rs2_busy,
  output logic                      o_rd_busy,
  output logic                      o_rd_wren,
  output logic [ADDR_W-1:0]         o_rd_addr,
  output logic [DATA_W-1:0]         o_rd_data
);

  localparam int ID_W     = id_w(NUM_REQ);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_win_id;
  logic                w_any;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;

  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_rr_ptr_nxt;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_rd_wren;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_rd_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_valid (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_id    (w_win_id),
    .o_any   (w_any)
  );

  // No requester may see a handshake while reset is held, otherwise it
  // would drop a write the output stage never captures.
  assign w_accept    = w_any & ~i_rst;
  assign o_req_ready = i_rst ? '0 : w_grant;

  // One-hot grant selects the winning slice.
  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_win_addr = i_req_addr[k*ADDR_W +: ADDR_W];
        w_win_data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // The requester after the winner gets top priority next cycle.
  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_accept) begin
      if (w_win_id == ID_W'(NUM_REQ - 1)) w_rr_ptr_nxt = '0;
      else                                w_rr_ptr_nxt = w_win_id + ID_W'(1);
    end
  end

  // Scoreboard next state. Ordering encodes precedence: commit-clear is
  // overridden by a same-cycle issue-set, and flush overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rd_wren) w_busy_nxt[r_rd_addr] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) w_busy_nxt[i_issue_rd] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  // Output stage, arbitration pointer and scoreboard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_wren <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_rr_ptr  <= '0;
      r_busy    <= '0;
    end else begin
      // x0 writes complete the handshake but never reach the register file.
      r_rd_wren <= w_accept && (w_win_addr != '0);
      if (w_accept) begin
        r_rd_addr <= w_win_addr;
        r_rd_data <= w_win_data;
      end
      r_rr_ptr <= w_rr_ptr_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign o_rd_wren  = r_rd_wren;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_data  = r_rd_data;

  assign o_rs1_busy = r_busy[i_rs1_addr];
  assign o_rs2_busy = r_busy[i_rs2_addr];
  assign o_rd_busy  = r_busy[i_issue_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  localparam int N  = RF_NUM_REQ;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int NR = 2 ** AW;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [N-1:0]      i_req_valid;
  logic [N*AW-1:0]   i_req_addr;
  logic [N*DW-1:0]   i_req_data;
  logic [N-1:0]      o_req_ready;
  logic              i_issue_valid;
  logic [AW-1:0]     i_issue_rd;
  logic              i_flush;
  logic [AW-1:0]     i_rs1_addr;
  logic [AW-1:0]     i_rs2_addr;
  logic              o_rs1_busy;
  logic              o_rs2_busy;
  logic              o_rd_busy;
  logic              o_rd_wren;
  logic [AW-1:0]     o_rd_addr;
  logic [DW-1:0]     o_rd_data;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_req_data    (i_req_data),
    .o_req_ready   (o_req_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_flush       (i_flush),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_rd_busy     (o_rd_busy),
    .o_rd_wren     (o_rd_wren),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Requester side: each one holds its request until accepted.
  bit      t_v [N];
  wb_req_t t_req [N];

  // Reference model state.
  int       m_ptr;
  bit       m_busy [NR];
  bit       m_wren;
  int       m_addr;
  logic [DW-1:0] m_data;

  // Values observed in the most recent cycle, for literal pins.
  logic [N-1:0]  s_ready;
  logic          s_wren;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic          s_rs1, s_rs2, s_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_wren = 0;
    m_addr = 0;
    m_data = '0;
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model to the state after the next rising edge.
  task automatic cycle(input bit rst, input bit iss_v, input int rd,
                       input bit flush, input int rs1, input int rs2);
    int win;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    i_rst         = rst;
    i_issue_valid = iss_v;
    i_issue_rd    = AW'(rd);
    i_flush       = flush;
    i_rs1_addr    = AW'(rs1);
    i_rs2_addr    = AW'(rs2);
    for (int k = 0; k < N; k++) begin
      i_req_valid[k]            = t_v[k];
      i_req_addr[k*AW +: AW]    = t_req[k].addr;
      i_req_data[k*DW +: DW]    = t_req[k].data;
    end
    if (rst) model_reset();
    #1;
    win = -1;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && t_v[(m_ptr + i) % N]) win = (m_ptr + i) % N;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", 64'(o_req_ready), 64'(exp_ready));
    chk("rd_wren",   64'(o_rd_wren),   64'(m_wren));
    chk("rd_addr",   64'(o_rd_addr),   64'(m_addr));
    chk("rd_data",   64'(o_rd_data),   64'(m_data));
    chk("rs1_busy",  64'(o_rs1_busy),  64'(m_busy[rs1]));
    chk("rs2_busy",  64'(o_rs2_busy),  64'(m_busy[rs2]));
    chk("rd_busy",   64'(o_rd_busy),   64'(m_busy[rd]));
    s_ready = o_req_ready; s_wren = o_rd_wren; s_addr = o_rd_addr;
    s_data  = o_rd_data;   s_rs1  = o_rs1_busy; s_rs2 = o_rs2_busy;
    s_rd    = o_rd_busy;
    if (!rst) begin
      if (m_wren) m_busy[m_addr] = 0;
      if (iss_v && rd != 0) m_busy[rd] = 1;
      if (flush) for (int r = 0; r < NR; r++) m_busy[r] = 0;
      if (win >= 0) begin
        m_wren = (t_req[win].addr != 0);
        m_addr = int'(t_req[win].addr);
        m_data = t_req[win].data;
        m_ptr  = (win + 1) % N;
        t_v[win] = 0;
      end else begin
        m_wren = 0;
      end
    end
  endtask

  task automatic idle(input int rs1);
    cycle(0, 0, 0, 0, rs1, 0);
  endtask

  task automatic post(input int k, input int addr, input logic [DW-1:0] data);
    t_v[k] = 1;
    t_req[k].addr = AW'(addr);
    t_req[k].data = data;
  endtask

  initial begin
    i_rst = 1'b1; i_req_valid = '0; i_req_addr = '0; i_req_data = '0;
    i_issue_valid = 1'b0; i_issue_rd = '0; i_flush = 1'b0;
    i_rs1_addr = '0; i_rs2_addr = '0;
    for (int k = 0; k < N; k++) begin t_v[k] = 0; t_req[k] = '0; end
    model_reset();

    // Reset held with every requester valid.
    for (int k = 0; k < N; k++) post(k, k + 1, 32'hA000_0000 + DW'(k));
    for (int c = 0; c < 3; c++) cycle(1, 0, 0, 0, 0, 0);
    chk("pin_rst_ready", 64'(s_ready), 64'h0);
    chk("pin_rst_wren",  64'(s_wren),  64'h0);

    // Contention: ALU, LSU, MUL, ALU, LSU, MUL.
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < N; k++) post(k, k + 1, 32'hB000_0000 + DW'(c * 4 + k));
      cycle(0, 0, 0, 0, 0, 0);
      chk("pin_rr_grant", 64'(s_ready), 64'(1) << (c % 3));
      chk("pin_rr_wren",  64'(s_wren),  (c == 0) ? 64'h0 : 64'h1);
    end
    for (int k = 0; k < N; k++) t_v[k] = 0;
    idle(0);
    chk("pin_rr_last_addr", 64'(s_addr), 64'h3);

    // Scoreboard life cycle on x5.
    cycle(0, 1, 5, 0, 5, 0);
    chk("pin_issue_same_cycle", 64'(s_rs1), 64'h0);
    idle(5); chk("pin_busy_after_issue", 64'(s_rs1), 64'h1);
    idle(5); idle(5);
    post(int'(REQ_LSU), 5, 32'hDEAD_BEEF);
    idle(5); chk("pin_lsu_grant", 64'(s_ready), 64'h2);
    idle(5);
    chk("pin_x5_wren", 64'(s_wren), 64'h1);
    chk("pin_x5_data", 64'(s_data), 64'hDEAD_BEEF);
    chk("pin_x5_still_busy", 64'(s_rs1), 64'h1);
    idle(5); chk("pin_x5_cleared", 64'(s_rs1), 64'h0);

    // Set and clear of x7 in the same cycle: set wins.
    cycle(0, 1, 7, 0, 7, 0);
    post(int'(REQ_ALU), 7, 32'h7777_0000);
    idle(7);
    cycle(0, 1, 7, 0, 7, 0);
    chk("pin_x7_commit", 64'(s_wren), 64'h1);
    idle(7); chk("pin_x7_set_wins", 64'(s_rs1), 64'h1);

    // x0: accepted but dropped; issue to x0 never marks busy.
    post(int'(REQ_MUL), 0, 32'h1234_5678);
    idle(0); chk("pin_x0_grant", 64'(s_ready), 64'h4);
    cycle(0, 1, 0, 0, 0, 0); chk("pin_x0_wren", 64'(s_wren), 64'h0);
    cycle(0, 0, 0, 0, 0, 0); chk("pin_x0_busy", 64'(s_rd), 64'h0);

    // Flush with busy 3 and 9 and a write to x3 in the output stage.
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 1, 9, 0, 0, 0);
    post(int'(REQ_ALU), 3, 32'h3333_3333);
    idle(0);
    cycle(0, 1, 10, 1, 3, 9);
    chk("pin_flush_commit", 64'(s_wren), 64'h1);
    chk("pin_flush_addr",   64'(s_addr), 64'h3);
    cycle(0, 0, 10, 0, 3, 9);
    chk("pin_flush_rs1", 64'(s_rs1), 64'h0);
    chk("pin_flush_rs2", 64'(s_rs2), 64'h0);
    chk("pin_flush_beats_set", 64'(s_rd), 64'h0);

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) post(k, 20 + k, DW'($urandom));
      cycle(0, 1, 20 + c, 0, 20, 21);
    end
    cycle(1, 0, 0, 0, 20, 21);
    chk("pin_async_wren",  64'(s_wren),  64'h0);
    chk("pin_async_ready", 64'(s_ready), 64'h0);
    chk("pin_async_busy",  64'(s_rs1),   64'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!t_v[k] && $urandom_range(0, 2) != 0) begin
          post(k, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, NR - 1)),
               DW'($urandom));
        end
      end
      cycle(($urandom_range(0, 199) == 0),
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, NR - 1)),
            ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, NR - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller for the 32x32 register file. Shares the register file's single write port between several write-back requesters (ALU, LSU, MUL) using round-robin arbitration with valid/ready handshakes. Registers the winning write into an output stage that drives the register file write port. Keeps a busy scoreboard of in-flight destination registers so that issue logic can stall on read-after-write (RAW) and write-after-write (WAW) hazards.

## Interface
- NUM_REQ, 3, number of write-back requesters; index 0 = ALU, 1 = LSU, 2 = MUL
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; 2**ADDR_W registers
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  NUM_REQ  requester k has a write pending
- i_req_addr  in  NUM_REQ*ADDR_W  destination register of requester k, in slice k
- i_req_data  in  NUM_REQ*DATA_W  write data of requester k, in slice k
- o_req_ready  out  NUM_REQ  one-hot grant; requester k's write is accepted this cycle
- i_issue_valid  in  1  an instruction with a destination register is issuing
- i_issue_rd  in  ADDR_W  destination register of the issuing instruction
- i_flush  in  1  pipeline flush; clears the scoreboard
- i_rs1_addr, i_rs2_addr  in  ADDR_W  hazard query addresses
- o_rs1_busy, o_rs2_busy, o_rd_busy  out  1  busy bit of i_rs1_addr, i_rs2_addr and i_issue_rd
- o_rd_wren  out  1  to the register file write enable
- o_rd_addr  out  ADDR_W  to the register file write address
- o_rd_data  out  DATA_W  to the register file write data

## Operation
- Arbitration:
  - Round-robin pointer `rr_ptr` gives the highest-priority requester. Reset value 0.
  - Winner is the first requester with valid set, searching from `rr_ptr` upward and wrapping.
  - `o_req_ready` is one-hot on the winner. It is all-zero when no request is valid.
  - Handshake: valid & ready. A requester holds valid, addr and data stable until accepted.
- Pointer update: on accept of requester w, `rr_ptr` <= (w+1) mod NUM_REQ. With no accept, `rr_ptr` holds.
- Output stage:
  - On accept: o_rd_wren <= (addr != 0), o_rd_addr <= addr, o_rd_data <= data.
  - With no accept: o_rd_wren <= 0. Address and data hold their previous values.
  - Writes to register 0 are accepted and dropped.
- Scoreboard: `busy[2**ADDR_W]`, one bit per register; busy[0] is constant 0.
  - Set: i_issue_valid & (i_issue_rd != 0) sets busy[i_issue_rd].
  - Clear: o_rd_wren clears busy[o_rd_addr]. The clear takes effect at the edge that commits the write.
  - Set and clear of the same register in the same cycle: set wins.
  - i_flush clears every bit. Flush beats a simultaneous set. A write already in the output stage still commits.
- Busy outputs: combinational reads of the registered `busy` array. No internal forwarding.
- WAW rule: issue logic does not issue while o_rd_busy=1. The block does not check this.
- The register file is always write-ready. The output stage therefore never back-pressures, and one write is accepted per cycle.

## Timing
- During and after reset, until the first accept:
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - o_req_ready=0 while i_rst=1.
  - All busy bits 0; all busy outputs 0.
- Accept in cycle N:
  - o_rd_wren=1 during N+1.
  - Register file written at the end of N+1; data readable from N+2.
  - busy bit clears at the end of N+1; o_rsX_busy=0 from N+2.
- Issue in cycle N: o_rsX_busy=1 from N+1.
- Back-to-back accepts: one per cycle, no bubbles. Under continuous contention, each requester is granted once every NUM_REQ cycles.
- Reset asserted mid-operation:
  - Asynchronous clear of the output stage, `rr_ptr` and `busy`.
  - The pending output-stage write is lost.

## Structure
- Package `rf_ctrl_pkg`:
  - NUM_REQ, DATA_W and ADDR_W defaults.
  - `req_id_t` (clog2 of NUM_REQ bits).
  - Requester index constants REQ_ALU, REQ_LSU, REQ_MUL.
  - `wb_req_t` struct holding {addr, data}.
- Sub-module `rr_arbiter`:
  - Parameterised NUM_REQ.
  - Inputs: valid vector, `rr_ptr`.
  - Outputs: one-hot grant, winner id, any-grant flag.
  - Purely combinational; the pointer register lives in the top.

## Test plan
- Reset: hold i_rst with all requests valid → o_req_ready=000, o_rd_wren=0, all busy outputs 0. Release reset → ALU granted first.
- Contention: all three valid for 6 cycles, addr = 1/2/3 → grants ALU, LSU, MUL, ALU, LSU, MUL. o_rd_wren=1 each cycle, one cycle after each grant.
- Scoreboard life cycle:
  - Issue rd=5 in cycle 0 → o_rs1_busy(5)=1 from cycle 1.
  - LSU writes 0xDEADBEEF to x5 in cycle 4 → o_rd_wren=1 in cycle 5, busy=0 from cycle 6.
- Set/clear collision: output stage commits x7 while issue rd=7 in the same cycle → busy[7] remains 1.
- x0 handling:
  - MUL writes 0x12345678 to x0 → o_req_ready[2]=1, o_rd_wren stays 0.
  - Issue rd=0 → o_rd_busy stays 0.
- Flush and reset mid-flight:
  - i_flush with busy 3,9 set and a pending write to x3 → all busy bits 0 next cycle; the x3 write still appears on o_rd_wren.
  - Async i_rst pulse mid-burst → outputs return to zero immediately.
